// File: rtl/booth_pp_gen_27.sv
// Radix-4 Booth partial-product generator with a single registered output
// stage and valid/ready handshaking on both sides. Row j is digit_j * A,
// sign-extended to DATA_WIDTH and shifted left by 2j. The rows sum to the
// full product mod 2^DATA_WIDTH.

// One Booth row: selects 0/+-A/+-2A from a 3-bit recoding window.
module booth_pp_row #(
    parameter int DATA_WIDTH = 106,
    parameter int OP_WIDTH   = 53,
    parameter int SHIFT      = 0
) (
    input  logic [OP_WIDTH:0]     a_ext,
    input  logic [2:0]            sel,
    output logic [DATA_WIDTH-1:0] row,
    output logic                  neg
);
    logic [DATA_WIDTH-1:0] a_sx;
    logic [DATA_WIDTH-1:0] mag;
    logic [DATA_WIDTH-1:0] row_full;

    assign a_sx = {{(DATA_WIDTH-OP_WIDTH-1){a_ext[OP_WIDTH]}}, a_ext};

    // Magnitude select. Window 111 is -0, so it yields a zero row and no negate.
    always_comb begin
        mag = '0;
        unique case (sel)
            3'b001, 3'b010, 3'b101, 3'b110: mag = a_sx;
            3'b011, 3'b100:                 mag = a_sx << 1;
            default:                        mag = '0;
        endcase
        neg      = sel[2] & ~(sel[1] & sel[0]);
        row_full = neg ? (~mag + 1'b1) : mag;
        row      = row_full << SHIFT;
    end
endmodule

module booth_pp_gen_27 #(
    parameter int  DATA_WIDTH = 106,
    parameter int  OP_WIDTH   = 53,
    localparam int NPP        = (OP_WIDTH + 1) / 2
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      is_signed,
    input  logic [OP_WIDTH-1:0]       op_a,
    input  logic [OP_WIDTH-1:0]       op_b,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NPP*DATA_WIDTH-1:0] pp,
    output logic [NPP-1:0]            neg
);
    logic [OP_WIDTH:0]         a_ext;
    logic [OP_WIDTH:0]         b_ext;
    logic [OP_WIDTH+1:0]       b_pad;
    logic [NPP*DATA_WIDTH-1:0] row_bus;
    logic [NPP-1:0]            row_neg;

    logic [NPP*DATA_WIDTH-1:0] pp_d, pp_q;
    logic [NPP-1:0]            neg_d, neg_q;
    logic                      out_valid_d, out_valid_q;
    logic                      accept;
    logic                      load;

    // Extension bit is the sign for signed operands, zero otherwise; the
    // appended zero at the bottom of b is the implicit bit -1 of digit 0.
    assign a_ext = {is_signed & op_a[OP_WIDTH-1], op_a};
    assign b_ext = {is_signed & op_b[OP_WIDTH-1], op_b};
    assign b_pad = {b_ext, 1'b0};

    for (genvar j = 0; j < NPP; j++) begin : g_row
        booth_pp_row #(
            .DATA_WIDTH (DATA_WIDTH),
            .OP_WIDTH   (OP_WIDTH),
            .SHIFT      (2 * j)
        ) u_row (
            .a_ext (a_ext),
            .sel   (b_pad[2*j +: 3]),
            .row   (row_bus[j*DATA_WIDTH +: DATA_WIDTH]),
            .neg   (row_neg[j])
        );
    end

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    // A flushed input is discarded outright, so the data regs are left alone.
    assign load     = accept && !flush;

    // Output stage next state: flush wins, then a new load, then a drain.
    always_comb begin
        out_valid_d = out_valid_q;
        pp_d        = pp_q;
        neg_d       = neg_q;
        if (flush)                          out_valid_d = 1'b0;
        else if (accept)                    out_valid_d = 1'b1;
        else if (out_valid_q && out_ready)  out_valid_d = 1'b0;
        if (load) begin
            pp_d  = row_bus;
            neg_d = row_neg;
        end
    end

    // Output register with async clear.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            out_valid_q <= 1'b0;
            pp_q        <= '0;
            neg_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            pp_q        <= pp_d;
            neg_q       <= neg_d;
        end
    end

    assign out_valid = out_valid_q;
    assign pp        = pp_q;
    assign neg       = neg_q;
endmodule
